// File: rtl/colour_conversion_sequencer.sv
// YUV->RGB conversion sequencer: walks Y/U/V planes per lane group,
// strobes per-lane channel loads, conversion and pipelined RGB writes.
module colour_conversion_sequencer #(
  parameter int ADDR_W   = 18,
  parameter int NUM_PIX  = 38400,
  parameter int LANES    = 2,
  parameter int DP_LAT   = 2,
  parameter int OUT_BASE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stall,
  output logic                 clear,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic [3*LANES-1:0]   ld_lane,
  output logic                 conv_en,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [1:0]           wr_lane,
  output logic [1:0]           wr_ch,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = $clog2(NUM_PIX) + 1;
  localparam int NL = 3 * LANES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]     rd_base, wr_base;
  logic [1:0]        rd_lane, rd_ch;
  logic [1:0]        wl_q, wc_q;
  logic              ld_vld;
  logic [3:0]        ld_idx;
  logic              cv_vld;
  logic [DP_LAT-1:0] dly;
  logic              wr_act;

  logic rd_go, rd_grp_end, rd_last;
  logic wr_go, wr_grp_end, wr_last;

  logic [ADDR_W-1:0] ch_off, rp, wp;

  assign rd_go      = (state == S_RUN) && !stall;
  assign rd_grp_end = (rd_ch == 2'd2) && (rd_lane == 2'(LANES-1));
  assign rd_last    = rd_grp_end && (rd_base == PW'(NUM_PIX-LANES));

  // write run is kicked by the delayed conv pulse and sustained by wr_act
  assign wr_go      = (wr_act || dly[DP_LAT-1]) && !stall;
  assign wr_grp_end = (wc_q == 2'd2) && (wl_q == 2'(LANES-1));
  assign wr_last    = wr_grp_end && (wr_base == PW'(NUM_PIX-LANES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!stall) begin
      unique case (state)
        S_IDLE:  if (start) state_nx = S_CLEAR;
        S_CLEAR: state_nx = S_RUN;
        S_RUN:   if (rd_last) state_nx = S_DRAIN;
        S_DRAIN: if (wr_go && wr_last) state_nx = S_DONE;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_base <= '0;
      rd_lane <= '0;
      rd_ch   <= '0;
      wr_base <= '0;
      wl_q    <= '0;
      wc_q    <= '0;
      ld_vld  <= 1'b0;
      ld_idx  <= '0;
      cv_vld  <= 1'b0;
      dly     <= '0;
      wr_act  <= 1'b0;
    end else if (!stall) begin
      if (state == S_CLEAR || state == S_DONE) begin
        rd_base <= '0;
        rd_lane <= '0;
        rd_ch   <= '0;
        wr_base <= '0;
        wl_q    <= '0;
        wc_q    <= '0;
        ld_vld  <= 1'b0;
        ld_idx  <= '0;
        cv_vld  <= 1'b0;
        dly     <= '0;
        wr_act  <= 1'b0;
      end else begin
        if (rd_go) begin
          if (rd_ch == 2'd2) begin
            rd_ch <= '0;
            if (rd_lane == 2'(LANES-1)) begin
              rd_lane <= '0;
              rd_base <= rd_base + PW'(LANES);
            end else begin
              rd_lane <= rd_lane + 2'd1;
            end
          end else begin
            rd_ch <= rd_ch + 2'd1;
          end
        end
        ld_vld <= rd_go;
        ld_idx <= 4'(3 * rd_lane + rd_ch);
        cv_vld <= ld_vld && (ld_idx == 4'(NL-1));
        dly[0] <= cv_vld;
        for (int i = 1; i < DP_LAT; i++) dly[i] <= dly[i-1];
        if (wr_go) begin
          if (wr_grp_end) begin
            wr_act  <= 1'b0;
            wc_q    <= '0;
            wl_q    <= '0;
            wr_base <= wr_base + PW'(LANES);
          end else begin
            wr_act <= 1'b1;
            if (wc_q == 2'd2) begin
              wc_q <= '0;
              wl_q <= wl_q + 2'd1;
            end else begin
              wc_q <= wc_q + 2'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    ch_off = '0;
    unique case (1'b1)
      rd_ch == 2'd1: ch_off = ADDR_W'(NUM_PIX);
      rd_ch == 2'd2: ch_off = ADDR_W'(2 * NUM_PIX);
      default:       ch_off = '0;
    endcase
  end

  assign rp = ADDR_W'(rd_base) + ADDR_W'(rd_lane);
  assign wp = ADDR_W'(wr_base) + ADDR_W'(wl_q);

  assign busy    = (state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN);
  assign clear   = (state == S_CLEAR) && !stall;
  assign done    = (state == S_DONE) && !stall;
  assign rd_en   = rd_go;
  assign ld_lane = (ld_vld && !stall) ? (NL'(1) << ld_idx) : '0;
  assign conv_en = cv_vld && !stall;
  assign wr_en   = wr_go;
  assign wr_lane = wl_q;
  assign wr_ch   = wc_q;
  assign rd_addr = busy ? (ch_off + rp) : '0;
  assign wr_addr = busy ? (ADDR_W'(OUT_BASE) + (wp << 1) + wp + ADDR_W'(wc_q)) : '0;

endmodule
